mem_read_responder: RTL and testbench

//  Memory-side responder to the cache fill controller: accepts word read/write requests
//  (enable, addr, wr, data_in) and returns read data a fixed LATENCY cycles later with a
//  one-cycle data_valid strobe. Fully pipelined, one request per cycle. Sits between
//  the I/D cache fill FSM and the main memory array; serves as both RTL model and bench memory.

---
 rtl/mem_read_responder_pkg.sv | 11 +
 rtl/mem_delay_line.sv | 41 ++++
 rtl/mem_read_responder.sv | 93 +++++++++
 tb/tb_mem_read_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_responder_pkg.sv
// Shared memory-side constants: word/address geometry and default read latency.
// The cache fill controller imports the same package so both sides agree on sizes.
package mem_read_responder_pkg;

   localparam int DEF_DATA_WIDTH = 16;  // bits per memory word
   localparam int DEF_ADDR_WIDTH = 16;  // byte address width, bit 0 ignored
   localparam int DEF_IDX_BITS   = 10;  // 2**IDX_BITS words in the array
   localparam int DEF_LATENCY    = 4;   // read issue to data_valid, legal 1..8
   localparam int CNT_WIDTH      = 4;   // holds 0..8 in-flight reads without wrap

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-depth shift register of {valid,data}. Only the valid bits are cleared by
// reset, so dropping in-flight reads costs no reset fan-out on the data path.
module mem_delay_line #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   // Valid bits shift one stage per cycle and are cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Data stages shift alongside the valid bits; contents are don't-care when invalid.
   always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
         data_q[i] <= data_q[i-1];
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side responder for the cache fill controller. Word reads return exactly
// LATENCY cycles after issue with a one-cycle data_valid strobe; writes update the
// array at the end of their cycle. One request per cycle, no backpressure.
//
// Handshake: a request is taken in every cycle with enable=1 (there is no ready);
// the requester must accept each data_valid cycle as it appears, in issue order.
module mem_read_responder
   import mem_read_responder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int IDX_BITS   = DEF_IDX_BITS,
   parameter int LATENCY    = DEF_LATENCY   // legal range 1..8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  outstanding
);

   localparam int WORDS = 1 << IDX_BITS;

   logic [DATA_WIDTH-1:0] mem_array [WORDS];
   logic [IDX_BITS-1:0]   word_idx;
   logic                  rd_issue;
   logic                  wr_issue;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  line_valid;
   logic [DATA_WIDTH-1:0] line_data;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_next;
   logic                  busy_q;

   // addr[0] selects a byte within the word and upper bits alias onto the array.
   assign word_idx = addr[IDX_BITS:1];
   assign rd_issue = enable & ~wr;
   assign wr_issue = enable & wr;
   assign rd_word  = mem_array[word_idx];

   // Array write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_issue) begin
         mem_array[word_idx] <= data_in;
      end
   end

   // Read data is captured into the first stage at issue, so later writes to the
   // same word cannot change a read already in flight.
   mem_delay_line #(
      .DEPTH (LATENCY),
      .WIDTH (DATA_WIDTH)
   ) u_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_issue),
      .in_data   (rd_word),
      .out_valid (line_valid),
      .out_data  (line_data)
   );

   // Next in-flight count: +1 on issue, -1 on return, unchanged when both happen.
   always_comb begin
      cnt_next = cnt_q;
      case ({rd_issue, line_valid})
         2'b10:   cnt_next = cnt_q + 4'd1;
         2'b01:   cnt_next = cnt_q - 4'd1;
         default: cnt_next = cnt_q;
      endcase
   end

   // In-flight counter and busy flag, both dropped by reset with the delay line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_next;
         busy_q <= (cnt_next != '0);
      end
   end

   assign outstanding = cnt_q;
   assign busy        = busy_q;
   assign data_valid  = line_valid;
   assign data_out    = line_valid ? line_data : '0;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder with LATENCY=4, IDX_BITS=10.
module tb_mem_read_responder;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic        busy;
   logic [3:0]  outstanding;

   int n_vec;
   int n_err;

   mem_read_responder #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (16),
      .IDX_BITS   (10),
      .LATENCY    (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .wr          (wr),
      .addr        (addr),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .busy        (busy),
      .outstanding (outstanding)
   );

   // Clock and initial reset level
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are then sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      enable  = 1'b0;
      wr      = 1'b0;
      addr    = 16'h0000;
      data_in = 16'h0000;
   endtask

   task automatic drive_read(input logic [15:0] a);
      enable  = 1'b1;
      wr      = 1'b0;
      addr    = a;
      data_in = 16'h0000;
   endtask

   task automatic drive_write(input logic [15:0] a, input logic [15:0] d);
      enable  = 1'b1;
      wr      = 1'b1;
      addr    = a;
      data_in = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_read(16'h0010);
      repeat (3) tick();
      n_vec++;
      if (data_valid !== 1'b0 || data_out !== 16'h0000 || busy !== 1'b0 || outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL reset: dv=%b dout=%h busy=%b outst=%0d, required 0/0000/0/0",
                  data_valid, data_out, busy, outstanding);
      end
      drive_idle();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_then_read();
      drive_write(16'h0010, 16'h1234);
      tick();
      n_vec++;
      if (data_valid !== 1'b0 || outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL wr_no_effect: dv=%b outst=%0d, required 0/0", data_valid, outstanding);
      end
      drive_read(16'h0010);
      tick();
      drive_idle();
      n_vec++;
      if (outstanding !== 4'd1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rd_issue_count: outst=%0d busy=%b, required 1/1", outstanding, busy);
      end
      repeat (2) tick();
      n_vec++;
      if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
         n_err++;
         $display("FAIL rd_early: dv=%b dout=%h, required 0/0000", data_valid, data_out);
      end
      tick();
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
         n_err++;
         $display("FAIL rd_after_wr: dv=%b dout=%h, required 1/1234", data_valid, data_out);
      end
      tick();
      n_vec++;
      if (data_valid !== 1'b0 || data_out !== 16'h0000 || outstanding !== 4'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL rd_strobe_end: dv=%b dout=%h outst=%0d busy=%b, required 0/0000/0/0",
                  data_valid, data_out, outstanding, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d;
      logic        exp_v;
      logic [3:0]  exp_o;
      int          ret;
      int          iss;
      for (int i = 0; i < 8; i++) begin
         drive_write(16'h00A0 + 16'(2 * i), 16'h00A0 + 16'(i));
         tick();
      end
      drive_read(16'h00A0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c < 8) drive_read(16'h00A0 + 16'(2 * c));
         else       drive_idle();
         iss   = (c < 8) ? c : 8;
         ret   = (c <= 4) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
         exp_o = 4'(iss - ret);
         exp_v = (c >= 4) && (c <= 11);
         exp_d = exp_v ? 16'h00A0 + 16'(c - 4) : 16'h0000;
         n_vec++;
         if (data_valid !== exp_v || data_out !== exp_d || outstanding !== exp_o) begin
            n_err++;
            $display("FAIL burst c=%0d: dv=%b dout=%h outst=%0d, required %b/%h/%0d",
                     c, data_valid, data_out, outstanding, exp_v, exp_d, exp_o);
         end
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL burst_busy: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_capture_at_issue();
      drive_write(16'h0020, 16'h1111);
      tick();
      drive_read(16'h0020);
      tick();
      drive_write(16'h0020, 16'h2222);
      tick();
      drive_read(16'h0020);
      tick();
      drive_idle();
      tick();
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 16'h1111) begin
         n_err++;
         $display("FAIL capture_old: dv=%b dout=%h, required 1/1111", data_valid, data_out);
      end
      tick();
      n_vec++;
      if (data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL capture_gap: dv=%b, required 0", data_valid);
      end
      tick();
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 16'h2222) begin
         n_err++;
         $display("FAIL capture_new: dv=%b dout=%h, required 1/2222", data_valid, data_out);
      end
      tick();
   endtask

   task automatic test_reset_in_flight();
      int dv_seen;
      drive_read(16'h0010);
      tick();
      drive_read(16'h0020);
      tick();
      n_vec++;
      if (outstanding !== 4'd2 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL flight_pre: outst=%0d busy=%b, required 2/1", outstanding, busy);
      end
      drive_read(16'h00A0);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (outstanding !== 4'd0 || busy !== 1'b0 || data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flight_async: outst=%0d busy=%b dv=%b, required 0/0/0",
                  outstanding, busy, data_valid);
      end
      tick();
      drive_idle();
      rst_n = 1'b1;
      dv_seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (data_valid !== 1'b0 || outstanding !== 4'd0 || busy !== 1'b0) dv_seen++;
      end
      n_vec++;
      if (dv_seen !== 0) begin
         n_err++;
         $display("FAIL flight_dropped: bad cycles=%0d, required 0", dv_seen);
      end
   endtask

   task automatic test_alias();
      drive_write(16'h0802, 16'hBEEF);
      tick();
      drive_read(16'h0002);
      tick();
      drive_read(16'h0003);
      tick();
      drive_idle();
      repeat (2) tick();
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
         n_err++;
         $display("FAIL alias_hi: dv=%b dout=%h, required 1/beef", data_valid, data_out);
      end
      tick();
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
         n_err++;
         $display("FAIL alias_b0: dv=%b dout=%h, required 1/beef", data_valid, data_out);
      end
      tick();
      n_vec++;
      if (data_valid !== 1'b0 || outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL alias_end: dv=%b outst=%0d, required 0/0", data_valid, outstanding);
      end
   endtask

   // Test sequence and final report
   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive_idle();
      #2;
      test_reset();
      test_write_then_read();
      test_back_to_back();
      test_capture_at_issue();
      test_reset_in_flight();
      test_alias();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
